piso_framer: RTL and testbench
==============================

// Module: piso_framer
// PURPOSE
//  Parametrised parallel-in/serial-out framer; successor to the fixed 32-bit converter.
//  Accepts one DATA_W word per handshake and transmits only the enabled lanes, LSB first.
//  Each lane is followed by a parity bit. The block then waits for ack/nack from the link
//  partner and retransmits up to MAX_RETRY times. Sits between the parallel producer and
//  the serial link PHY.
// PARAMETERS
//  DATA_W      32  parallel word width; must be a multiple of LANE_W
//  LANE_W      8   bits per lane (parity granule)
//  NUM_LANES   DATA_W/LANE_W  derived; do not override
//  ACK_TIMEOUT 8   cycles to wait for ack/nack after the last bit (>=1)
//  MAX_RETRY   3   retransmissions allowed after the first attempt (0 = none)
//  PARITY_ODD  0   0: parity = ^lane; 1: parity = ~^lane
// PORTS
//  clk_i      in   1          clock, rising edge
//  rst_i      in   1          synchronous reset, active high
//  p_i        in   DATA_W     parallel data
//  valid_i    in   1          p_i/byte_en_i valid
//  byte_en_i  in   NUM_LANES  lane enables; bit k enables p_i[k*LANE_W +: LANE_W]
//  rdy_o      out  1          block can accept a word
//  s_o        out  1          serial data
//  valid_o    out  1          s_o carries a frame bit this cycle
//  last_o     out  1          final bit of the frame (qualified by valid_o)
//  ack_i      in   1          partner accepted the frame
//  nack_i     in   1          partner requests retransmission
//  done_o     out  1          one-cycle pulse: frame finished
//  err_o      out  1          valid with done_o: 1 = retries exhausted
// BEHAVIOUR
//  Reset values: rdy_o=1, s_o=0, valid_o=0, last_o=0, done_o=0, err_o=0.
//    Internal: state=IDLE, counters=0.
//  All outputs are registered except rdy_o, which is decoded from state (1 only in IDLE).
//  Accept: valid_i && rdy_o at a rising edge captures p_i and byte_en_i.
//    valid_i while rdy_o=0 is ignored and nothing is latched.
//  FSM IDLE -> SEND -> WAIT -> DONE -> IDLE.
//  IDLE: on accept, go to SEND if byte_en_i != 0.
//    If byte_en_i == 0, go straight to DONE (done_o=1, err_o=0); no bits are sent.
//  SEND: for each enabled lane, ascending index, emit LANE_W data bits LSB first, then
//    1 parity bit. Disabled lanes are skipped with no gap cycles.
//    valid_o=1 on every frame bit. s_o=0 whenever valid_o=0.
//    First bit appears in the cycle after the accept edge.
//    Frame length = popcount(en)*(LANE_W+1) cycles, back-to-back.
//    last_o=1 only with the parity bit of the highest enabled lane.
//    The cycle after last_o, go to WAIT with the timeout counter at 0.
//  WAIT: samples ack_i/nack_i each cycle and increments the timeout counter.
//    ack_i -> DONE, err_o=0. ack_i && nack_i in the same cycle: ack wins.
//    nack_i, or counter reaching ACK_TIMEOUT with no response:
//      if retry_cnt < MAX_RETRY: retry_cnt++, back to SEND from the first enabled lane;
//        the first retransmitted bit appears in the next cycle;
//      else DONE with err_o=1.
//    The latched word and enables are unchanged across retries.
//  ack_i/nack_i outside WAIT (including the last_o cycle) are ignored.
//  DONE: lasts one cycle with done_o=1 and rdy_o=0, then IDLE. retry_cnt clears on accept.
//  rst_i mid-frame: aborts immediately. Next cycle all outputs hold reset values.
//    No done_o pulse is generated; the partially sent frame is not resumed.
//  Counters: bit_cnt $clog2(LANE_W+1), lane_idx $clog2(NUM_LANES),
//    tmo_cnt $clog2(ACK_TIMEOUT+1), retry_cnt $clog2(MAX_RETRY+1). No wrap is reachable.
// STRUCTURE
//  Package piso_pkg: state enum piso_state_e {IDLE,SEND,WAIT,DONE}.
//    Also function lane_parity(lane, odd).
//  Sub-module piso_lane_sel: combinational priority pick of the next enabled lane
//    >= a given index from the en mask; outputs idx, found, is_last.
//  Top module holds the FSM, data/enable registers, counters and output registers.
// TESTING
//  T1 p_i=32'hA5C3_0F01, en=4'b1111, ack 2 cycles after last -> 36 valid bits.
//    Lane0 bits 1,0,0,0,0,0,0,0 then parity 1. last_o on bit 36. done_o=1, err_o=0.
//  T2 en=4'b0101, p_i=32'h00FF_00FF -> 18 bits: lane0 eight 1s + parity 0,
//    lane2 eight 1s + parity 0. Lanes 1 and 3 absent.
//  T3 en=4'b0001, nack in WAIT cycle 1 twice, then ack -> frame sent 3 times,
//    identical bits. done_o with err_o=0.
//  T4 no ack/nack, MAX_RETRY=3 -> 4 transmissions, each followed by 8 WAIT cycles.
//    Then done_o=1, err_o=1; rdy_o=1 the following cycle.
//  T5 rst_i asserted at bit 10 of a frame -> next cycle valid_o=0, rdy_o=1.
//    A fresh accept sends a correct frame. ack+nack together in WAIT -> treated as ack.
//  T6 en=4'b0000 accepted -> no valid_o. done_o pulse the 1st cycle after accept, err_o=0.
//    valid_i held during SEND is never latched.

Source files
------------

// File: rtl/piso_framer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : piso_pkg                                                     |
// | Description : Shared types and helpers for the piso_framer block: FSM      |
// |               state enumeration and the per-lane parity function.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } piso_state_e;

    // Widest lane the parity helper supports; narrower lanes are zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int LANE_MAX_W = 64;

    function automatic logic lane_parity(input logic [LANE_MAX_W-1:0] lane,
                                         input logic                  odd);
        return (^lane) ^ odd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_framer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : piso_framer_if                                               |
// | Description : Producer-side handshake, serial link outputs and partner     |
// |               ack/nack for piso_framer.                                    |
// |   slave  : framer view (p_i, valid_i, byte_en_i, ack_i, nack_i in;         |
// |            rdy_o, s_o, valid_o, last_o, done_o, err_o out)                 |
// |   master : producer / link-partner view (directions reversed)              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface piso_framer_if #(
    parameter int DATA_W = 32,
    parameter int LANE_W = 8
);
    localparam int NUM_LANES = DATA_W / LANE_W;

    logic [DATA_W-1:0]    p_i;
    logic                 valid_i;
    logic [NUM_LANES-1:0] byte_en_i;
    logic                 rdy_o;
    logic                 s_o;
    logic                 valid_o;
    logic                 last_o;
    logic                 ack_i;
    logic                 nack_i;
    logic                 done_o;
    logic                 err_o;

    modport slave (
        input  p_i, valid_i, byte_en_i, ack_i, nack_i,
        output rdy_o, s_o, valid_o, last_o, done_o, err_o
    );

    modport master (
        output p_i, valid_i, byte_en_i, ack_i, nack_i,
        input  rdy_o, s_o, valid_o, last_o, done_o, err_o
    );

endinterface
`default_nettype wire

// File: rtl/piso_framer_lane_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : piso_lane_sel                                                |
// | Description : Combinational priority pick of the lowest enabled lane whose |
// |               index is >= i_start.                                         |
// |   i_en      : lane enable mask                                             |
// |   i_start   : first index to consider (may equal NUM_LANES = none)         |
// |   o_idx     : selected lane index (0 when nothing found)                   |
// |   o_found   : an enabled lane exists at or above i_start                   |
// |   o_is_last : selected lane is the highest enabled lane in the mask        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module piso_lane_sel #(
    parameter int NUM_LANES = 4,
    parameter int IDX_W     = 2
) (
    input  wire  [NUM_LANES-1:0] i_en,
    input  wire  [IDX_W:0]       i_start,
    output logic [IDX_W-1:0]     o_idx,
    output logic                 o_found,
    output logic                 o_is_last
);

    always_comb begin
        o_idx     = '0;
        o_found   = 1'b0;
        o_is_last = 1'b0;
        // Scan downwards so the lowest qualifying lane is the one left standing.
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (i_en[k] && (k >= int'(i_start))) begin
                o_idx   = IDX_W'(k);
                o_found = 1'b1;
            end
        end
        o_is_last = o_found;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (i_en[k] && (k > int'(o_idx))) begin
                o_is_last = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/piso_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : piso_framer                                                  |
// | Description : Parallel-in/serial-out framer. Sends the enabled lanes of a  |
// |               captured word LSB first, each followed by a parity bit, then |
// |               waits for ack/nack and retransmits up to MAX_RETRY times.    |
// |   clk_i : clock, rising edge                                               |
// |   rst_i : synchronous reset, active high                                   |
// |   bus   : piso_framer_if.slave (handshake, serial out, ack/nack, status)   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module piso_framer
    import piso_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int LANE_W      = 8,
    parameter int NUM_LANES   = DATA_W / LANE_W,
    parameter int ACK_TIMEOUT = 8,
    parameter int MAX_RETRY   = 3,
    parameter int PARITY_ODD  = 0
) (
    input wire            clk_i,
    input wire            rst_i,
    piso_framer_if.slave  bus
);

    localparam int c_LIDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int c_BIT_W  = $clog2(LANE_W + 1);
    localparam int c_BSEL_W = (LANE_W > 1) ? $clog2(LANE_W) : 1;
    localparam int c_TMO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int c_RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] c_ST_IDLE = IDLE;
    localparam logic [1:0] c_ST_SEND = SEND;
    localparam logic [1:0] c_ST_WAIT = WAIT;
    localparam logic [1:0] c_ST_DONE = DONE;

    logic [1:0]                       r_state;
    logic [NUM_LANES-1:0][LANE_W-1:0] r_data;
    logic [NUM_LANES-1:0]             r_en;
    logic [c_LIDX_W-1:0]              r_lane_idx;
    logic                             r_lane_last;
    logic [c_BIT_W-1:0]               r_bit_cnt;
    logic [c_TMO_W-1:0]               r_tmo_cnt;
    logic [c_RTY_W-1:0]               r_retry_cnt;
    logic                             r_s;
    logic                             r_valid;
    logic                             r_last;
    logic                             r_done;
    logic                             r_err;

    logic [NUM_LANES-1:0]             w_first_en;
    logic [NUM_LANES-1:0][LANE_W-1:0] w_first_src;
    logic [c_LIDX_W-1:0]              w_first_idx;
    logic                             w_first_found;
    logic                             w_first_is_last;
    logic                             w_first_bit;
    logic [c_LIDX_W:0]                w_next_start;
    logic [c_LIDX_W-1:0]              w_next_idx;
    logic                             w_next_found;
    logic                             w_next_is_last;
    logic [LANE_W-1:0]                w_cur_lane;
    logic [c_BSEL_W-1:0]              w_bit_sel;
    logic                             w_parity;
    logic [c_TMO_W-1:0]               w_tmo_next;

    // In IDLE the first lane comes straight from the bus so the first bit can
    // leave in the cycle after the accept edge; on a retry it comes from the
    // latched copy.
    assign w_first_en  = (r_state == c_ST_IDLE) ? bus.byte_en_i : r_en;
    assign w_first_src = (r_state == c_ST_IDLE) ? bus.p_i : r_data;
    assign w_first_bit = w_first_src[w_first_idx][0];

    piso_lane_sel #(
        .NUM_LANES (NUM_LANES),
        .IDX_W     (c_LIDX_W)
    ) u_first_sel (
        .i_en      (w_first_en),
        .i_start   ('0),
        .o_idx     (w_first_idx),
        .o_found   (w_first_found),
        .o_is_last (w_first_is_last)
    );

    assign w_next_start = {1'b0, r_lane_idx} + 1'b1;

    piso_lane_sel #(
        .NUM_LANES (NUM_LANES),
        .IDX_W     (c_LIDX_W)
    ) u_next_sel (
        .i_en      (r_en),
        .i_start   (w_next_start),
        .o_idx     (w_next_idx),
        .o_found   (w_next_found),
        .o_is_last (w_next_is_last)
    );

    assign w_cur_lane = r_data[r_lane_idx];
    assign w_bit_sel  = r_bit_cnt[c_BSEL_W-1:0];
    assign w_parity   = lane_parity(LANE_MAX_W'(w_cur_lane), (PARITY_ODD != 0));
    assign w_tmo_next = r_tmo_cnt + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_ST_IDLE;
            r_data      <= '0;
            r_en        <= '0;
            r_lane_idx  <= '0;
            r_lane_last <= 1'b0;
            r_bit_cnt   <= '0;
            r_tmo_cnt   <= '0;
            r_retry_cnt <= '0;
            r_s         <= 1'b0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.valid_i) begin
                        r_data      <= bus.p_i;
                        r_en        <= bus.byte_en_i;
                        r_retry_cnt <= '0;
                        if (w_first_found) begin
                            r_state     <= c_ST_SEND;
                            r_s         <= w_first_bit;
                            r_valid     <= 1'b1;
                            r_last      <= 1'b0;
                            r_lane_idx  <= w_first_idx;
                            r_lane_last <= w_first_is_last;
                            r_bit_cnt   <= c_BIT_W'(1);
                        end else begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                c_ST_SEND: begin
                    if (r_last) begin
                        // Final parity bit is on the wire this cycle.
                        r_state   <= c_ST_WAIT;
                        r_s       <= 1'b0;
                        r_valid   <= 1'b0;
                        r_last    <= 1'b0;
                        r_tmo_cnt <= '0;
                    end else if (r_bit_cnt < c_BIT_W'(LANE_W)) begin
                        r_s       <= w_cur_lane[w_bit_sel];
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end else begin
                        r_s       <= w_parity;
                        r_last    <= r_lane_last;
                        r_bit_cnt <= '0;
                        if (w_next_found) begin
                            r_lane_idx  <= w_next_idx;
                            r_lane_last <= w_next_is_last;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (bus.ack_i) begin
                        r_state <= c_ST_DONE;
                        r_done  <= 1'b1;
                    end else if (bus.nack_i || (w_tmo_next == c_TMO_W'(ACK_TIMEOUT))) begin
                        if (r_retry_cnt < c_RTY_W'(MAX_RETRY)) begin
                            r_retry_cnt <= r_retry_cnt + 1'b1;
                            r_state     <= c_ST_SEND;
                            r_s         <= w_first_bit;
                            r_valid     <= 1'b1;
                            r_last      <= 1'b0;
                            r_lane_idx  <= w_first_idx;
                            r_lane_last <= w_first_is_last;
                            r_bit_cnt   <= c_BIT_W'(1);
                        end else begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end else begin
                        r_tmo_cnt <= w_tmo_next;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rdy_o   = (r_state == c_ST_IDLE);
    assign bus.s_o     = r_s;
    assign bus.valid_o = r_valid;
    assign bus.last_o  = r_last;
    assign bus.done_o  = r_done;
    assign bus.err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_piso_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_piso_framer                                               |
// | Description : Self-checking bench for piso_framer: directed vector table,  |
// |               hand-written reset/hold sequences and randomized frames      |
// |               checked against a lane-level frame model.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_piso_framer;

    localparam int DATA_W      = 32;
    localparam int LANE_W      = 8;
    localparam int NUM_LANES   = 4;
    localparam int ACK_TIMEOUT = 8;
    localparam int MAX_RETRY   = 3;
    localparam int PARITY_ODD  = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    piso_framer_if #(.DATA_W(DATA_W), .LANE_W(LANE_W)) bus ();

    piso_framer #(
        .DATA_W      (DATA_W),
        .LANE_W      (LANE_W),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .MAX_RETRY   (MAX_RETRY),
        .PARITY_ODD  (PARITY_ODD)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    // Response codes per attempt: 0 = silence (timeout), k = ack in WAIT cycle k,
    // 100+k = nack in cycle k, 200+k = ack and nack together in cycle k.
    typedef struct {
        logic [31:0] p;
        logic [3:0]  en;
        int          r0, r1, r2, r3;
        int          exp_len;
        int          exp_tx;
        logic        exp_err;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    bit   exp_q[$];
    bit   got_q[$];
    bit   first_q[$];
    int   n_tx;
    logic err_seen;
    bit   poke_ack_last;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Frame model: enabled lanes ascending, each LSB-first followed by parity.
    function automatic void build_frame(input logic [31:0] p, input logic [3:0] en);
        logic [LANE_W-1:0] lane;
        exp_q.delete();
        for (int l = 0; l < NUM_LANES; l++) begin
            if (en[l]) begin
                lane = p[l*LANE_W +: LANE_W];
                for (int b = 0; b < LANE_W; b++) exp_q.push_back(lane[b]);
                exp_q.push_back((^lane) ^ (PARITY_ODD != 0));
            end
        end
    endfunction

    function automatic logic [63:0] pack_got();
        logic [63:0] v = '0;
        for (int i = 0; i < got_q.size() && i < 64; i++) v[i] = got_q[i];
        return v;
    endfunction

    function automatic logic [63:0] pack_exp();
        logic [63:0] v = '0;
        for (int i = 0; i < exp_q.size() && i < 64; i++) v[i] = exp_q[i];
        return v;
    endfunction

    function automatic logic [63:0] pack_first();
        logic [63:0] v = '0;
        for (int i = 0; i < first_q.size() && i < 64; i++) v[i] = first_q[i];
        return v;
    endfunction

    // Collects serial bits from the current cycle until last_o; returns with the
    // last_o cycle current. A gap inside the frame or no end within the budget
    // leaves ok=0.
    task automatic capture(output bit ok);
        ok = 1'b0;
        got_q.delete();
        for (int c = 0; c < 300; c++) begin
            if (bus.valid_o) begin
                got_q.push_back(bus.s_o);
                if (bus.last_o) begin
                    ok = 1'b1;
                    break;
                end
            end else if (got_q.size() != 0) begin
                break;
            end
            tick();
        end
    endtask

    task automatic check_frame(input string name);
        bit ok;
        ok = (got_q.size() == exp_q.size());
        if (ok) foreach (got_q[i]) if (got_q[i] !== exp_q[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual len=%0d bits=%0h required len=%0d bits=%0h",
                     name, got_q.size(), pack_got(), exp_q.size(), pack_exp());
        end
    endtask

    task automatic run_txn(input logic [31:0] p, input logic [3:0] en,
                           input int r0, input int r1, input int r2, input int r3);
        int   resp[4];
        int   kind, cyc;
        bit   ok, acked;
        resp = '{r0, r1, r2, r3};
        build_frame(p, en);
        n_tx     = 0;
        err_seen = 1'b0;
        first_q.delete();
        check("rdy_before_accept", {63'd0, bus.rdy_o}, 64'd1);
        bus.p_i       = p;
        bus.byte_en_i = en;
        bus.valid_i   = 1'b1;
        tick();
        bus.valid_i   = 1'b0;
        bus.p_i       = $urandom;
        bus.byte_en_i = 4'($urandom);
        if (en == 4'b0000) begin
            check("empty_done", {60'd0, bus.done_o, bus.err_o, bus.valid_o, bus.rdy_o}, 64'b1000);
        end else begin
            check("first_bit_latency", {63'd0, bus.valid_o}, 64'd1);
            for (int a = 0; a <= MAX_RETRY; a++) begin
                check("rdy_busy", {63'd0, bus.rdy_o}, 64'd0);
                capture(ok);
                if (!ok) begin
                    checks++;
                    failures++;
                    $display("FAIL frame_end actual=no_last_o required=last_o within budget");
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    return;
                end
                check_frame("frame_bits");
                n_tx++;
                if (a == 0) first_q = got_q;
                kind = resp[a] / 100;
                cyc  = (resp[a] == 0) ? ACK_TIMEOUT : (resp[a] % 100);
                if (poke_ack_last && a == 0) bus.ack_i = 1'b1;
                tick();
                bus.ack_i = 1'b0;
                for (int c = 1; c < cyc; c++) tick();
                check("wait_quiet", {60'd0, bus.valid_o, bus.done_o, bus.last_o, bus.s_o}, 64'd0);
                if (resp[a] != 0) begin
                    bus.ack_i  = (kind == 0 || kind == 2);
                    bus.nack_i = (kind == 1 || kind == 2);
                end
                tick();
                bus.ack_i  = 1'b0;
                bus.nack_i = 1'b0;
                acked = (resp[a] != 0) && (kind == 0 || kind == 2);
                if (acked || a == MAX_RETRY) begin
                    check("done_err", {62'd0, bus.done_o, bus.err_o}, {62'd0, 1'b1, !acked});
                    err_seen = bus.err_o;
                    break;
                end
                check("retransmit_start", {62'd0, bus.valid_o, bus.done_o}, 64'b10);
            end
        end
        tick();
        check("back_idle", {61'd0, bus.done_o, bus.rdy_o, bus.valid_o}, 64'b010);
    endtask

    vec_t vecs[8];

    initial begin
        int          cnt, bad, rs[4], tx_exp;
        logic        err_exp;
        logic [31:0] p;
        logic [3:0]  en;
        bit          ok;

        bus.p_i = '0; bus.valid_i = 1'b0; bus.byte_en_i = '0;
        bus.ack_i = 1'b0; bus.nack_i = 1'b0;
        poke_ack_last = 1'b0;

        vecs[0] = '{32'hA5C3_0F01, 4'b1111,   2,   0,   0,   0, 36, 1, 1'b0};
        vecs[1] = '{32'h00FF_00FF, 4'b0101,   1,   0,   0,   0, 18, 1, 1'b0};
        vecs[2] = '{32'h1234_5678, 4'b0001, 101, 101,   1,   0,  9, 3, 1'b0};
        vecs[3] = '{32'hDEAD_BEEF, 4'b1111,   0,   0,   0,   0, 36, 4, 1'b1};
        vecs[4] = '{32'h0F0F_0F0F, 4'b0110, 203,   0,   0,   0, 18, 1, 1'b0};
        vecs[5] = '{32'h8000_0001, 4'b1010, 102,   0,   8,   0, 18, 3, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF, 4'b0000,   1,   0,   0,   0,  0, 0, 1'b0};
        vecs[7] = '{32'h1357_2468, 4'b1000, 105, 105, 105, 105,  9, 4, 1'b1};

        // Reset state
        repeat (3) tick();
        check("reset_outputs", {58'd0, bus.rdy_o, bus.s_o, bus.valid_o, bus.last_o, bus.done_o, bus.err_o},
              64'b100000);
        rst = 1'b0;
        tick();

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            poke_ack_last = (i == 0);
            run_txn(vecs[i].p, vecs[i].en, vecs[i].r0, vecs[i].r1, vecs[i].r2, vecs[i].r3);
            check("vec_len", 64'(first_q.size()), 64'(vecs[i].exp_len));
            check("vec_tx", 64'(n_tx), 64'(vecs[i].exp_tx));
            check("vec_err", {63'd0, err_seen}, {63'd0, vecs[i].exp_err});
            if (i == 0) check("t1_lane0_bits", {55'd0, pack_first()[8:0]}, 64'b1_0000_0001);
            if (i == 1) check("t2_bits", pack_first(), 64'h1FEFF);
        end
        poke_ack_last = 1'b0;

        // Reset in the middle of a frame (bit 10 on the wire)
        bus.p_i = 32'h1234_ABCD; bus.byte_en_i = 4'b1111; bus.valid_i = 1'b1;
        tick();
        bus.valid_i = 1'b0;
        cnt = bus.valid_o ? 1 : 0;
        for (int c = 0; c < 40 && cnt < 10; c++) begin
            tick();
            if (bus.valid_o) cnt++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_abort", {59'd0, bus.valid_o, bus.rdy_o, bus.done_o, bus.last_o, bus.s_o}, 64'b01000);
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.done_o || bus.valid_o) bad++;
        end
        check("rst_no_resume", 64'(bad), 64'd0);
        run_txn(32'hCAFE_F00D, 4'b1111, 201, 0, 0, 0);
        check("post_rst_tx", 64'(n_tx), 64'd1);

        // valid_i held high through SEND must not latch the second word
        build_frame(32'h0000_81C7, 4'b0011);
        bus.p_i = 32'h0000_81C7; bus.byte_en_i = 4'b0011; bus.valid_i = 1'b1;
        tick();
        bus.p_i = 32'hFFFF_FFFF; bus.byte_en_i = 4'b1111;
        capture(ok);
        bus.valid_i = 1'b0;
        check("hold_frame_end", {63'd0, ok}, 64'd1);
        check_frame("hold_frame_bits");
        tick();
        bus.ack_i = 1'b1;
        tick();
        bus.ack_i = 1'b0;
        check("hold_done", {62'd0, bus.done_o, bus.err_o}, 64'b10);
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.valid_o || bus.done_o || !bus.rdy_o) bad++;
        end
        check("hold_not_latched", 64'(bad), 64'd0);

        // Randomized frames and partner behaviour
        for (int n = 0; n < 25; n++) begin
            p  = $urandom;
            en = 4'($urandom_range(0, 15));
            for (int a = 0; a < 4; a++) begin
                case ($urandom_range(0, 5))
                    0:       rs[a] = 0;
                    1, 2:    rs[a] = $urandom_range(1, ACK_TIMEOUT);
                    3, 4:    rs[a] = 100 + $urandom_range(1, ACK_TIMEOUT);
                    default: rs[a] = 200 + $urandom_range(1, ACK_TIMEOUT);
                endcase
            end
            tx_exp  = (MAX_RETRY + 1);
            err_exp = 1'b1;
            for (int a = 0; a <= MAX_RETRY; a++) begin
                if (rs[a] != 0 && (rs[a] / 100 != 1)) begin
                    tx_exp  = a + 1;
                    err_exp = 1'b0;
                    break;
                end
            end
            if (en == 4'b0000) begin
                tx_exp  = 0;
                err_exp = 1'b0;
            end
            run_txn(p, en, rs[0], rs[1], rs[2], rs[3]);
            check("rand_tx", 64'(n_tx), 64'(tx_exp));
            check("rand_err", {63'd0, err_seen}, {63'd0, err_exp});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
